// File: rtl/qcw_bridge_gen.sv
// Phase-shifted full-bridge gate-word generator for serializer-fed gate drivers.
// Each clock emits LANES serial samples per gate (two legs, A/B each), with dead time before rising edges.

module qcw_bridge_lane #(
    parameter int CW = 24,
    parameter int K  = 0
) (
    input  logic          clk_logic,
    input  logic          reset_n,
    input  logic [CW-1:0] pc_i,
    input  logic [CW-1:0] p_i,
    input  logic [CW-1:0] ps_i,
    input  logic          stop_wrap_i,
    input  logic          vld1_i,
    input  logic [CW-1:0] p1_i,
    input  logic [CW-1:0] h1_i,
    input  logic [CW-1:0] dt1_i,
    input  logic [CW-1:0] hd1_i,
    output logic          a1_o,
    output logic          b1_o,
    output logic          a2_o,
    output logic          b2_o
);
    logic [CW:0]   sum;
    logic          past_wrap;
    logic [CW-1:0] s_c, t_c;
    logic [CW-1:0] s_q, t_q;
    logic          mask_q, live;

    // Single conditional subtract is enough: pc < P and K < LANES <= P/2.
    always_comb begin
        sum       = {1'b0, pc_i} + (CW+1)'(K);
        past_wrap = (sum >= {1'b0, p_i});
        s_c       = past_wrap ? sum[CW-1:0] - p_i : sum[CW-1:0];
        t_c       = (s_c >= ps_i) ? s_c - ps_i : s_c + (p_i - ps_i);
    end

    assign live = vld1_i & ~mask_q;

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            s_q    <= '0;
            t_q    <= '0;
            mask_q <= 1'b0;
            a1_o   <= 1'b0;
            b1_o   <= 1'b0;
            a2_o   <= 1'b0;
            b2_o   <= 1'b0;
        end else begin
            s_q    <= s_c;
            t_q    <= t_c;
            mask_q <= stop_wrap_i & past_wrap;
            a1_o   <= live & (s_q >= dt1_i) & (s_q < h1_i);
            b1_o   <= live & (s_q >= hd1_i) & (s_q < p1_i);
            a2_o   <= live & (t_q >= dt1_i) & (t_q < h1_i);
            b2_o   <= live & (t_q >= hd1_i) & (t_q < p1_i);
        end
    end
endmodule

module qcw_bridge_gen #(
    parameter int LANES = 8,
    parameter int CW    = 24
) (
    input  logic             clk_logic,
    input  logic             reset_n,
    input  logic [CW-1:0]    period,
    input  logic [CW-1:0]    phase_shift,
    input  logic [CW-1:0]    dead_time,
    input  logic             load,
    input  logic             enable,
    output logic [LANES-1:0] gdt1_a,
    output logic [LANES-1:0] gdt1_b,
    output logic [LANES-1:0] gdt2_a,
    output logic [LANES-1:0] gdt2_b,
    output logic             out_ref,
    output logic             cycle_done,
    output logic             running,
    output logic             cfg_err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] pc_q, pc_d;
    logic [CW-1:0] p_q, p_d, ps_q, ps_d, dt_q, dt_d;
    logic [CW-1:0] sp_q, sp_d, sps_q, sps_d, sdt_q, sdt_d;
    logic          cfg_err_q, cfg_err_d;
    logic [CW:0]   nxt;
    logic          active, wrap, stop_wrap, cfg_ok;

    // Stage-1 copies of the per-word configuration so stage 2 compares against the right period.
    logic          vld1_q, wrap1_q, done_q;
    logic [CW-1:0] p1_q, h1_q, dt1_q, hd1_q;

    assign cfg_ok    = ({1'b0, period} >= (CW+1)'(2*LANES)) && (phase_shift < period)
                       && (dead_time < (period >> 1));
    assign active    = (state_q != S_IDLE);
    assign nxt       = {1'b0, pc_q} + (CW+1)'(LANES);
    assign wrap      = active && (nxt >= {1'b0, p_q});
    assign stop_wrap = (state_q == S_STOP) && !enable && wrap;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        p_d       = p_q;
        ps_d      = ps_q;
        dt_d      = dt_q;
        sp_d      = sp_q;
        sps_d     = sps_q;
        sdt_d     = sdt_q;
        cfg_err_d = cfg_err_q;
        if (load) begin
            cfg_err_d = !cfg_ok;
            if (cfg_ok) begin
                sp_d  = period;
                sps_d = phase_shift;
                sdt_d = dead_time;
            end
        end
        case (state_q)
            S_IDLE: if (enable) begin
                cfg_err_d = !cfg_ok;
                if (cfg_ok) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    p_d     = period;
                    ps_d    = phase_shift;
                    dt_d    = dead_time;
                    sp_d    = period;
                    sps_d   = phase_shift;
                    sdt_d   = dead_time;
                end
            end
            S_RUN:  if (!enable) state_d = S_STOP;
            S_STOP: begin
                if (enable)    state_d = S_RUN;
                else if (wrap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Shadow (already including a same-cycle load) takes effect from the next period.
        if (active) begin
            pc_d = wrap ? CW'(nxt - {1'b0, p_q}) : CW'(nxt);
            if (wrap) begin
                p_d  = sp_d;
                ps_d = sps_d;
                dt_d = sdt_d;
            end
        end
        if (stop_wrap) pc_d = '0;
    end

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            p_q       <= '0;
            ps_q      <= '0;
            dt_q      <= '0;
            sp_q      <= '0;
            sps_q     <= '0;
            sdt_q     <= '0;
            cfg_err_q <= 1'b0;
            vld1_q    <= 1'b0;
            wrap1_q   <= 1'b0;
            done_q    <= 1'b0;
            p1_q      <= '0;
            h1_q      <= '0;
            dt1_q     <= '0;
            hd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            p_q       <= p_d;
            ps_q      <= ps_d;
            dt_q      <= dt_d;
            sp_q      <= sp_d;
            sps_q     <= sps_d;
            sdt_q     <= sdt_d;
            cfg_err_q <= cfg_err_d;
            vld1_q    <= active;
            wrap1_q   <= wrap;
            done_q    <= vld1_q & wrap1_q;
            p1_q      <= p_q;
            h1_q      <= p_q >> 1;
            dt1_q     <= dt_q;
            hd1_q     <= (p_q >> 1) + dt_q;
        end
    end

    // Lane k is k-th sample in time, sent first-MSB on the wire.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        qcw_bridge_lane #(.CW(CW), .K(k)) u_lane (
            .clk_logic   (clk_logic),
            .reset_n     (reset_n),
            .pc_i        (pc_q),
            .p_i         (p_q),
            .ps_i        (ps_q),
            .stop_wrap_i (stop_wrap),
            .vld1_i      (vld1_q),
            .p1_i        (p1_q),
            .h1_i        (h1_q),
            .dt1_i       (dt1_q),
            .hd1_i       (hd1_q),
            .a1_o        (gdt1_a[LANES-1-k]),
            .b1_o        (gdt1_b[LANES-1-k]),
            .a2_o        (gdt2_a[LANES-1-k]),
            .b2_o        (gdt2_b[LANES-1-k])
        );
    end

    assign out_ref    = gdt1_a[0];
    assign cycle_done = done_q;
    assign running    = active;
    assign cfg_err    = cfg_err_q;
endmodule

// File: doc/qcw_bridge_gen.md
QCW_BRIDGE_GEN -- requirements
Module: qcw_bridge_gen

Interface
REQ-001 Parameter LANES, default 8, meaning samples per parallel word (serializer ratio); SHALL be a power of two, 2..16.
REQ-002 Parameter CW, default 24, meaning width of period/phase/dead-time quantities in serial-bit units.
REQ-003 clk_logic  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 period  input  CW  full bridge period P in serial bits.
REQ-006 phase_shift  input  CW  leg-2 delay PS relative to leg 1.
REQ-007 dead_time  input  CW  dead time DT inserted before each rising edge.
REQ-008 load  input  1  one-cycle strobe; captures period/phase_shift/dead_time into shadow registers.
REQ-009 enable  input  1  level; run request.
REQ-010 gdt1_a, gdt1_b, gdt2_a, gdt2_b  output  LANES each  registered gate words; bit LANES-1 is first in time on the wire.
REQ-011 out_ref  output  1  equals gdt1_a[0].
REQ-012 cycle_done  output  1  one-cycle pulse per period wrap.
REQ-013 running  output  1  high in RUN or STOP state.
REQ-014 cfg_err  output  1  sticky; set on rejected configuration, cleared by reset or next accepted configuration.

Function
REQ-015 States: IDLE, RUN, STOP; IDLE->RUN when enable=1 and inputs valid; RUN->STOP when enable=0; STOP->RUN when enable=1 before wrap; STOP->IDLE on wrap.
REQ-016 Valid configuration: P >= 2*LANES, PS < P, DT < (P>>1); otherwise cfg_err=1 and the configuration is not applied (IDLE stays IDLE).
REQ-017 IDLE->RUN: active P/PS/DT load directly from inputs, phase counter pc=0.
REQ-018 Counter: if pc+LANES >= P then pc <= pc+LANES-P and wrap=1, else pc <= pc+LANES; sums computed at CW+1 bits, no overflow.
REQ-019 Shadow: load captures inputs into shadow; shadow copies to active only in a wrap cycle, applying from the next period; load and wrap in the same cycle applies the newly loaded values.
REQ-020 Lane sample s_k = (pc+k) mod P for k=0..LANES-1 (single conditional subtract); lane k maps to word bit LANES-1-k.
REQ-021 Leg 2 sample t_k = s_k-PS if s_k >= PS else s_k+P-PS.
REQ-022 With H = P>>1: gdt1_a bit high iff DT <= s_k < H; gdt1_b high iff H+DT <= s_k < P; gdt2_a/gdt2_b identical using t_k.
REQ-023 A and B of one leg SHALL never be high in the same lane.
REQ-024 Latency: word for pc of cycle n appears on outputs at cycle n+2 (stage 1 registers s_k/t_k, stage 2 registers comparisons); cycle_done aligned with the word containing the wrap.
REQ-025 STOP wrap cycle: lanes with pc+k >= P masked to 0 on all four outputs; all later words 0.
REQ-026 IDLE: all words 0; pipeline stages carry a valid bit, invalid stages emit 0.
REQ-027 enable deasserted and reasserted within one period: no pc restart, no glitch.

Reset
REQ-028 reset_n=0 immediately forces all outputs 0, state IDLE, pc=0, active and shadow registers 0, cfg_err=0, pipeline valid bits 0.
REQ-029 Reset mid-period requires no completion; after release operation starts only on enable=1.

Verification
REQ-030 LANES=8, P=40, PS=0, DT=0, enable=1 -> gdt1_a per period 0xFF,0xFF,0xF0,0x00,0x00; gdt1_b 0x00,0x00,0x0F,0xFF,0xFF; cycle_done every 5th word.
REQ-031 As REQ-030 with DT=2 -> gdt1_a word0=0x3F; gdt1_b word2=0x03; A&B never both high.
REQ-032 P=40, PS=10, DT=0 -> gdt2_a 0x00,0x3F,0xFF,0xFC,0x00.
REQ-033 Running P=40, load P=48 mid-period -> current period completes at 40, next period 6 words, no truncated word.
REQ-034 P=44 running, enable dropped -> period finishes; wrap word has lanes past wrap masked 0; running falls; following words 0.
REQ-035 period=10 (<16) at enable -> cfg_err=1, state stays IDLE, outputs 0; reset_n pulse mid-run -> outputs 0 same cycle.
